ring_node: RTL and testbench

//  Per-core ring interface between a core's cache miss logic and the slot ring / memory read bus.

---
 rtl/ring_node_pkg.sv | 14 +
 rtl/ring_node.sv | 162 ++++++++++++++++
 tb/tb_ring_node.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_node_pkg.sv
// Shared ring slot definitions used by every ring stage and the memory controller.
// Slot type encodings live here only; nodes compare against these, never local copies.
package ring_node_pkg;

    localparam int SLOT_TYPE_W = 4;

    typedef enum logic [SLOT_TYPE_W-1:0] {
        SLOT_NULL  = 4'd0,
        SLOT_TOKEN = 4'd1,
        SLOT_ADDR  = 4'd2,
        SLOT_WDATA = 4'd3
    } slot_type_e;

endpackage

// File: rtl/ring_node.sv
// Per-core ring node: grabs the TOKEN to insert an ADDR slot (plus WDATA slots for a
// writeback), then collects the refill words addressed to this core from the mc read bus.
module ring_node
    import ring_node_pkg::*;
#(
    parameter int CORENUM     = 1,
    parameter int TSIZE       = 4,
    parameter int SSIZE       = 4,
    parameter int NBWORDS     = 3,
    parameter int NBCACHELINE = 27
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TSIZE-1:0]       slot_type_in,
    input  logic [SSIZE-1:0]       slot_source_in,
    input  logic [31:0]            slot_data_in,
    output logic [TSIZE-1:0]       slot_type_out,
    output logic [SSIZE-1:0]       slot_source_out,
    output logic [31:0]            slot_data_out,
    input  logic [SSIZE-1:0]       mc_dest,
    input  logic [NBWORDS-1:0]     mc_count,
    input  logic [31:0]            mc_data,
    input  logic                   req,
    input  logic                   req_write,
    input  logic [NBCACHELINE-1:0] req_line,
    output logic [NBWORDS-1:0]     wd_word,
    input  logic [31:0]            wd_data,
    output logic                   rd_valid,
    output logic [NBWORDS-1:0]     rd_word,
    output logic [31:0]            rd_data,
    output logic                   ack
);

    localparam int                 NWORDS   = 1 << NBWORDS;
    localparam logic [TSIZE-1:0]   T_NULL   = TSIZE'(SLOT_NULL);
    localparam logic [TSIZE-1:0]   T_TOKEN  = TSIZE'(SLOT_TOKEN);
    localparam logic [TSIZE-1:0]   T_ADDR   = TSIZE'(SLOT_ADDR);
    localparam logic [TSIZE-1:0]   T_WDATA  = TSIZE'(SLOT_WDATA);
    localparam logic [SSIZE-1:0]   MY_ID    = SSIZE'(CORENUM);
    localparam logic [NBWORDS-1:0] LAST_WRD = NBWORDS'(NWORDS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SEND, ST_REL, ST_RDAT} state_e;

    state_e               r_state, w_state_next;
    logic                 r_write, w_write_next;
    logic [NBWORDS-1:0]   r_wcnt, w_wcnt_next;
    logic                 r_rd_valid, w_rd_valid_next;
    logic [NBWORDS-1:0]   r_rd_word, w_rd_word_next;
    logic [31:0]          r_rd_data, w_rd_data_next;
    logic                 r_ack, w_ack_next;

    logic w_is_token, w_own_ret, w_free, w_capture;

    assign w_is_token = (slot_type_in == T_TOKEN);
    // Our own ADDR/WDATA slots have gone full circle: strip them and treat as empty.
    assign w_own_ret  = (slot_source_in == MY_ID) &&
                        ((slot_type_in == T_ADDR) || (slot_type_in == T_WDATA));
    assign w_free     = (slot_type_in == T_NULL) || w_own_ret;

    always_comb begin
        w_state_next    = r_state;
        w_write_next    = r_write;
        w_wcnt_next     = r_wcnt;
        w_rd_valid_next = 1'b0;
        w_rd_word_next  = r_rd_word;
        w_rd_data_next  = r_rd_data;
        w_ack_next      = 1'b0;
        w_capture       = 1'b0;
        if (w_own_ret) begin
            slot_type_out   = T_NULL;
            slot_source_out = '0;
            slot_data_out   = '0;
        end else begin
            slot_type_out   = slot_type_in;
            slot_source_out = slot_source_in;
            slot_data_out   = slot_data_in;
        end

        case (r_state)
            ST_IDLE: begin
                // Holding off while ack is high keeps a stale req from starting a second miss.
                if (req && !r_ack) begin
                    if (w_is_token) w_capture = 1'b1;
                    else            w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_is_token) w_capture = 1'b1;
            end
            ST_SEND: begin
                if (w_free) begin
                    slot_type_out   = T_WDATA;
                    slot_source_out = MY_ID;
                    slot_data_out   = wd_data;
                    w_wcnt_next     = r_wcnt + 1'b1;
                    if (r_wcnt == LAST_WRD) w_state_next = ST_REL;
                end
            end
            ST_REL: begin
                if (w_free) begin
                    slot_type_out   = T_TOKEN;
                    slot_source_out = '0;
                    slot_data_out   = '0;
                    if (r_write) begin
                        w_ack_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_RDAT;
                    end
                end
            end
            ST_RDAT: begin
                if (mc_dest == MY_ID) begin
                    w_rd_valid_next = 1'b1;
                    w_rd_word_next  = mc_count;
                    w_rd_data_next  = mc_data;
                    if (mc_count == LAST_WRD) begin
                        w_ack_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_capture) begin
            slot_type_out   = T_ADDR;
            slot_source_out = MY_ID;
            slot_data_out   = {{(31 - NBCACHELINE){1'b0}}, req_write, req_line};
            w_write_next    = req_write;
            w_wcnt_next     = '0;
            w_state_next    = req_write ? ST_SEND : ST_REL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_wcnt     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_word  <= '0;
            r_rd_data  <= '0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_write    <= w_write_next;
            r_wcnt     <= w_wcnt_next;
            r_rd_valid <= w_rd_valid_next;
            r_rd_word  <= w_rd_word_next;
            r_rd_data  <= w_rd_data_next;
            r_ack      <= w_ack_next;
        end
    end

    assign wd_word  = r_wcnt;
    assign rd_valid = r_rd_valid;
    assign rd_word  = r_rd_word;
    assign rd_data  = r_rd_data;
    assign ack      = r_ack;

endmodule

// File: tb/tb_ring_node.sv
// Scoreboard bench for ring_node: expected slots and refill words are queued as stimulus
// is driven and checked when the node produces them.
module tb_ring_node;

    localparam logic [3:0] T_NULL  = 4'd0;
    localparam logic [3:0] T_TOK   = 4'd1;
    localparam logic [3:0] T_ADDR  = 4'd2;
    localparam logic [3:0] T_WD    = 4'd3;

    typedef struct packed {
        logic [3:0]  t;
        logic [3:0]  s;
        logic [31:0] d;
    } slot_t;

    typedef struct packed {
        logic [2:0]  w;
        logic [31:0] d;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  slot_type_in, slot_source_in;
    logic [31:0] slot_data_in;
    logic [3:0]  slot_type_out, slot_source_out;
    logic [31:0] slot_data_out;
    logic [3:0]  mc_dest;
    logic [2:0]  mc_count;
    logic [31:0] mc_data;
    logic        req, req_write;
    logic [26:0] req_line;
    logic [2:0]  wd_word;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic [2:0]  rd_word;
    logic [31:0] rd_data;
    logic        ack;

    int n_vec = 0;
    int n_err = 0;
    slot_t exp_q[$];
    rd_t   rd_q[$];

    always #5 clk = ~clk;

    assign wd_data = 32'hD000_0000 | {29'd0, wd_word};

    ring_node #(.CORENUM(1), .TSIZE(4), .SSIZE(4), .NBWORDS(3), .NBCACHELINE(27)) dut (
        .clk(clk), .reset(reset),
        .slot_type_in(slot_type_in), .slot_source_in(slot_source_in), .slot_data_in(slot_data_in),
        .slot_type_out(slot_type_out), .slot_source_out(slot_source_out), .slot_data_out(slot_data_out),
        .mc_dest(mc_dest), .mc_count(mc_count), .mc_data(mc_data),
        .req(req), .req_write(req_write), .req_line(req_line),
        .wd_word(wd_word), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_word(rd_word), .rd_data(rd_data), .ack(ack)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic slot_t mk(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
        slot_t r;
        r.t = t; r.s = s; r.d = d;
        return r;
    endfunction

    // Called at a negedge: drive a slot, check the combinational output, then ack after the edge.
    task automatic step(input slot_t in_s, input slot_t ex, input logic ack_e);
        slot_t e;
        slot_type_in   = in_s.t;
        slot_source_in = in_s.s;
        slot_data_in   = in_s.d;
        exp_q.push_back(ex);
        #1;
        e = exp_q.pop_front();
        chk("slot_type", 32'(slot_type_out), 32'(e.t));
        chk("slot_src", 32'(slot_source_out), 32'(e.s));
        chk("slot_data", slot_data_out, e.d);
        @(posedge clk);
        #1;
        chk("ack", 32'(ack), 32'(ack_e));
        $display("slot in t=%0d s=%0d d=%h -> out t=%0d s=%0d d=%h ack=%0b",
                 in_s.t, in_s.s, in_s.d, e.t, e.s, e.d, ack);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                chk("rd_word", 32'(rd_word), 32'(r.w));
                chk("rd_data", rd_data, r.d);
                $display("refill word %0d data %h", rd_word, rd_data);
            end
        end
    end

    initial begin
        slot_t nul;
        slot_t tok;
        nul = mk(T_NULL, 4'd0, 32'd0);
        tok = mk(T_TOK, 4'd0, 32'd0);
        reset = 1'b1;
        slot_type_in = T_NULL; slot_source_in = 0; slot_data_in = 0;
        mc_dest = 0; mc_count = 0; mc_data = 0;
        req = 0; req_write = 0; req_line = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_word", 32'(rd_word), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wd_word", 32'(wd_word), 32'd0);
        reset = 1'b0;

        // Read, TOKEN present with req: ADDR in the same cycle.
        req = 1; req_write = 0; req_line = 27'h12;
        step(tok, mk(T_ADDR, 4'd1, 32'h0000_0012), 1'b0);
        step(mk(T_ADDR, 4'd2, 32'hAAAA), mk(T_ADDR, 4'd2, 32'hAAAA), 1'b0);
        step(nul, tok, 1'b0);
        for (int k = 0; k < 8; k++) begin
            mc_dest = 4'd1; mc_count = 3'(k); mc_data = 32'hC0DE_0000 | k;
            rd_q.push_back({3'(k), 32'hC0DE_0000 | k});
            step(nul, nul, k == 7);
        end
        mc_dest = 0; req = 0;
        step(nul, nul, 1'b0);

        // Writeback with foreign and returning own slots interleaved.
        req = 1; req_write = 1; req_line = 27'h5;
        step(tok, mk(T_ADDR, 4'd1, 32'h0800_0005), 1'b0);
        step(nul, mk(T_WD, 4'd1, 32'hD000_0000), 1'b0);
        step(mk(T_ADDR, 4'd3, 32'h1111), mk(T_ADDR, 4'd3, 32'h1111), 1'b0);
        step(nul, mk(T_WD, 4'd1, 32'hD000_0001), 1'b0);
        step(mk(T_ADDR, 4'd1, 32'h0800_0005), mk(T_WD, 4'd1, 32'hD000_0002), 1'b0);
        step(mk(T_WD, 4'd2, 32'h2222), mk(T_WD, 4'd2, 32'h2222), 1'b0);
        step(nul, mk(T_WD, 4'd1, 32'hD000_0003), 1'b0);
        step(mk(T_WD, 4'd1, 32'hD000_0000), mk(T_WD, 4'd1, 32'hD000_0004), 1'b0);
        for (int k = 5; k < 8; k++) step(nul, mk(T_WD, 4'd1, 32'hD000_0000 | k), 1'b0);
        step(mk(T_ADDR, 4'd2, 32'h3333), mk(T_ADDR, 4'd2, 32'h3333), 1'b0);
        step(nul, tok, 1'b1);
        // req still high during the ack cycle: a TOKEN here must pass, not start a new miss.
        step(tok, tok, 1'b0);
        req = 0;
        step(nul, nul, 1'b0);

        // req with no TOKEN for 20 cycles.
        req = 1; req_write = 0; req_line = 27'h7A;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] ty;
            slot_t s;
            case ($urandom_range(0, 3))
                0: ty = T_NULL;
                1: ty = T_ADDR;
                2: ty = T_WD;
                default: ty = 4'd5;
            endcase
            s = mk(ty, 4'($urandom_range(2, 15)), $urandom);
            step(s, s, 1'b0);
        end
        step(tok, mk(T_ADDR, 4'd1, 32'h0000_007A), 1'b0);
        step(nul, tok, 1'b0);
        for (int k = 0; k < 8; k++) begin
            mc_dest = 4'd2; mc_count = 3'(k); mc_data = 32'hDEAD_0000 | k;
            step(nul, nul, 1'b0);
        end
        mc_dest = 0;
        step(tok, tok, 1'b0);
        for (int k = 0; k < 8; k++) begin
            mc_dest = 4'd1; mc_count = 3'(k); mc_data = 32'hBEEF_0000 | k;
            rd_q.push_back({3'(k), 32'hBEEF_0000 | k});
            step(nul, nul, k == 7);
        end
        mc_dest = 0; req = 0;
        step(nul, nul, 1'b0);

        // mc traffic for us while idle is ignored.
        for (int k = 0; k < 4; k++) begin
            mc_dest = 4'd1; mc_count = 3'(k); mc_data = 32'h5555_0000 | k;
            step(nul, nul, 1'b0);
        end
        mc_dest = 0;
        chk("pre_rst_rd_word", 32'(rd_word), 32'd7);

        // Async reset in the middle of a writeback at word 3.
        req = 1; req_write = 1; req_line = 27'h3;
        step(tok, mk(T_ADDR, 4'd1, 32'h0800_0003), 1'b0);
        for (int k = 0; k < 3; k++) step(nul, mk(T_WD, 4'd1, 32'hD000_0000 | k), 1'b0);
        slot_type_in = T_NULL; slot_source_in = 0; slot_data_in = 0;
        #1;
        chk("pre_rst_wd_type", 32'(slot_type_out), 32'(T_WD));
        chk("pre_rst_wd_data", slot_data_out, 32'hD000_0003);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_slot_type", 32'(slot_type_out), 32'(T_NULL));
        chk("arst_wd_word", 32'(wd_word), 32'd0);
        chk("arst_rd_word", 32'(rd_word), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset = 1'b0; req = 0;
        for (int k = 0; k < 4; k++) step(nul, nul, 1'b0);

        chk("slot_q_left", 32'(exp_q.size()), 32'd0);
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
